// File: rtl/pwl_pkg.sv
// Coefficient tables and pipeline constants shared by the
// piecewise-linear reciprocal datapath.
package pwl_pkg;

   localparam int PWL_LATENCY = 2;

   typedef struct packed {
      logic [7:0] c;
      logic [3:0] a;
      logic [3:0] b;
   } pwl_coef_t;

   // Entry 0 sits in the low bits; constants are at W=8 scale.
   localparam logic [1:0][7:0] PWL_C2 = {8'h90, 8'hCC};
   localparam logic [1:0][3:0] PWL_A2 = {4'd2, 4'd1};
   localparam logic [1:0][3:0] PWL_B2 = {4'd4, 4'd3};

   localparam logic [3:0][7:0] PWL_C4 =
      {8'h88, 8'h9C, 8'hC0, 8'hDE};
   localparam logic [3:0][3:0] PWL_A4 =
      {4'd2, 4'd2, 4'd1, 4'd1};
   localparam logic [3:0][3:0] PWL_B4 =
      {4'd5, 4'd3, 4'd4, 4'd2};

   function automatic pwl_coef_t pwl_coef(
      input int         nseg,
      input logic [1:0] s
   );
      pwl_coef_t r;
      if (nseg == 4) begin
         r.c = PWL_C4[s];
         r.a = PWL_A4[s];
         r.b = PWL_B4[s];
      end else begin
         r.c = PWL_C2[s[0]];
         r.a = PWL_A2[s[0]];
         r.b = PWL_B2[s[0]];
      end
      return r;
   endfunction

endpackage

// File: rtl/pwl_segment_eval.sv
// Combinational segment evaluation: y = C - (x>>A) - (x>>B),
// clamped at zero.
module pwl_segment_eval
   import pwl_pkg::*;
#(
   parameter int MANT_WIDTH = 8,
   parameter int NSEG       = 2
) (
   input  logic [MANT_WIDTH-1:0] x_i,
   input  logic [1:0]            s_i,
   output logic [MANT_WIDTH-1:0] y_o
);

   localparam int W = MANT_WIDTH;

   pwl_coef_t          coef;
   logic [W:0]         c_ext;
   logic signed [W:0]  diff;

   always_comb begin
      coef  = pwl_coef(NSEG, s_i);
      // Table constants are 8-bit; scale them to the mantissa width.
      c_ext = (W+1)'({1'b0, coef.c}) << (W - 8);
      diff  = $signed(c_ext)
            - $signed({1'b0, x_i >> coef.a})
            - $signed({1'b0, x_i >> coef.b});
      y_o   = diff[W] ? '0 : diff[W-1:0];
   end

endmodule

// File: rtl/reciprocal_pwl_pipe.sv
// Two-stage pipelined PWL reciprocal of a normalised Q1.(W-1)
// mantissa, valid/ready on both sides.
module reciprocal_pwl_pipe
   import pwl_pkg::*;
#(
   parameter int MANT_WIDTH = 8,
   parameter int NSEG       = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [MANT_WIDTH-1:0] in_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [MANT_WIDTH-1:0] out_data,
   output logic                  out_err
);

   localparam int W = MANT_WIDTH;

   logic         v1_q, v2_q;
   logic         e1_q, e2_q;
   logic [W-1:0] x1_q, y2_q;
   logic [1:0]   s1_q;
   logic [1:0]   s_d;
   logic         e_d;
   logic [W-1:0] y_seg, y_d;
   logic         adv1, adv2;

   assign adv2     = !v2_q || out_ready;
   assign adv1     = !v1_q || adv2;
   assign in_ready = adv1;

   always_comb begin
      if (NSEG == 4) s_d = in_data[W-2 -: 2];
      else           s_d = {1'b0, in_data[W-2]};
      e_d = !in_data[W-1];
   end

   pwl_segment_eval #(
      .MANT_WIDTH (W),
      .NSEG       (NSEG)
   ) u_eval (
      .x_i (x1_q),
      .s_i (s1_q),
      .y_o (y_seg)
   );

   // Non-normalised inputs flow through in order with a zero result.
   assign y_d = e1_q ? '0 : y_seg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v1_q <= 1'b0;
         e1_q <= 1'b0;
         x1_q <= '0;
         s1_q <= '0;
      end else if (adv1) begin
         v1_q <= in_valid;
         if (in_valid) begin
            e1_q <= e_d;
            x1_q <= in_data;
            s1_q <= s_d;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v2_q <= 1'b0;
         e2_q <= 1'b0;
         y2_q <= '0;
      end else if (adv2) begin
         v2_q <= v1_q;
         if (v1_q) begin
            e2_q <= e1_q;
            y2_q <= y_d;
         end
      end
   end

   assign out_valid = v2_q;
   assign out_data  = y2_q;
   assign out_err   = e2_q;

endmodule

// File: doc/reciprocal_pwl_pipe.md
Name: reciprocal_pwl_pipe

Overview:
- Pipelined piecewise-linear reciprocal approximator for normalised mantissas x in [1,2) in Q1.F format, where F = MANT_WIDTH-1.
- Each segment computes y = C[s] - (x>>A[s]) - (x>>B[s]).
- Segment count is parametrised (2 or 4), with a valid/ready handshake on both sides and an error flag for non-normalised input.
- Feeds the normaliser stage of the pseudo-softmax divider path, replacing the single-stage 2-segment unit.

Parameters:
- MANT_WIDTH, 8, mantissa width W (Q1.(W-1)); legal range 8..16.
- NSEG, 2, number of PWL segments; legal values 2 or 4.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  block accepts in_data this cycle.
- in_data  input  W  mantissa x, Q1.(W-1).
- out_valid  output  1  out_data/out_err are valid.
- out_ready  input  1  downstream accepts this cycle.
- out_data  output  W  approximation of 1/x, Q1.(W-1).
- out_err  output  1  input MSB was 0 (non-normalised).

Behaviour:
- Reset is asynchronous and active-low. While rst_n=0: all pipeline valids=0, out_valid=0, out_data=0, out_err=0, and in_ready=1 once reset is released. Asserting reset mid-operation discards in-flight data with no output.
- Transfer occurs when valid and ready are both high on a rising clk edge.
- Pipeline structure:
  - Stage 1 registers x, the segment index s, and the err bit.
  - Stage 2 registers the arithmetic result.
  - Latency from input transfer to out_valid is exactly 2 cycles with no stall; throughput is 1 per cycle.
- Flow control:
  - adv2 = !v2 | out_ready; adv1 = !v1 | adv2; in_ready = adv1 (combinational).
  - A stalled stage holds its data unchanged. out_data must stay stable while out_valid=1 and out_ready=0.
- Segment select, where f = x[W-2:0]:
  - NSEG=2: s = f MSB.
  - NSEG=4: s = top 2 bits of f.
- Coefficients, with 8-bit constants shifted left by (W-8):
  - NSEG=2: C={0xCC,0x90}, A={1,2}, B={3,4}.
  - NSEG=4: C={0xDE,0xC0,0x9C,0x88}, A={1,1,2,2}, B={2,4,3,5}.
- Arithmetic:
  - Shifts are logical and truncating.
  - Subtractions are done in W+1 bits signed. A negative result saturates to 0. A result above 2^W-1 cannot occur for these constants; the bench asserts this.
- Error handling: if x MSB=0, set out_err=1 and force out_data=0; the transfer still completes in order.
- Ordering is strictly FIFO; no reordering or dropping.

Decomposition:
- Shared package pwl_pkg holds:
  - the coefficient tables for NSEG 2 and 4, stored as 8-bit constants plus shift pairs;
  - a function returning (C,A,B) given NSEG and s;
  - the latency constant PWL_LATENCY=2.
- Sub-module pwl_segment_eval (combinational): given x and s, returns the saturated y. It is instantiated once, between stage 1 and stage 2.
- Handshake/valid logic stays in the top module.

Test Plan:
1. W=8, NSEG=2, no stall: in_data 0x80 -> out_data 0x7C, out_err=0, out_valid exactly 2 cycles after the transfer.
2. W=8, NSEG=2: in_data 0xC0 -> 0x54; in_data 0xFF -> 0x42. Back-to-back with in_valid held high -> one result per cycle, in order.
3. W=8, NSEG=4: 0x80 -> 0x7E; 0xA0 -> 0x66. Sweep 0x80..0xFF: |y - 1/x| <= 0x03 LSB of the real value, y monotonically non-increasing.
4. Backpressure: stream 0x80,0xA0,0xC0,0xE0 with out_ready low for 5 cycles. in_ready falls after 2 accepted, out_data holds stable, and all 4 results emerge in order once out_ready rises.
5. Error input 0x40 -> out_err=1, out_data=0. The following input 0x80 completes normally.
6. Assert rst_n low with 2 items in flight -> out_valid=0 immediately (asynchronous). After release, no stale outputs; a new 0x80 -> 0x7C after 2 cycles.
